// File: rtl/spi_minion_pkg.sv
// spi_minion_pkg: shared frame layout helpers and FSM state type for the SPI minion front end
package spi_minion_pkg;
    localparam int NBITS = 8;

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        ACTIVE    = 2'd2
    } state_t;

    function automatic int val_wrt_bit(input int n);
        return n - 1;
    endfunction

    function automatic int val_rd_bit(input int n);
        return n - 2;
    endfunction

    function automatic int data_msb(input int n);
        return n - 3;
    endfunction
endpackage

// File: rtl/spi_minion_sync_edge.sv
// spi_minion_sync_edge: 2-flop synchroniser for a pad signal plus an edge-detect flop
module spi_minion_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic sync,
    output logic rise,
    output logic fall
);
    logic [2:0] s;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) s <= '0;
        else s <= {s[1:0], d};
    end

    assign sync = s[1];
    assign rise = s[1] & ~s[2];
    assign fall = ~s[1] & s[2];
endmodule

// File: rtl/spi_minion_frontend.sv
// spi_minion_frontend: recovers SPI mode-0 frames from pads into push/pull pulses and drives miso
module spi_minion_frontend
    import spi_minion_pkg::*;
#(
    parameter int nbits = NBITS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cs,
    input  logic             sclk,
    input  logic             mosi,
    output logic             miso,
    output logic             push_en,
    output logic             push_msg_val_wrt,
    output logic             push_msg_val_rd,
    output logic [nbits-3:0] push_msg_data,
    output logic             pull_en,
    input  logic             pull_msg_val,
    input  logic             pull_msg_spc,
    input  logic [nbits-3:0] pull_msg_data,
    output logic             frame_err
);
    localparam int CW = $clog2(nbits + 2);
    localparam int VAL_WRT_BIT = val_wrt_bit(nbits);
    localparam int VAL_RD_BIT = val_rd_bit(nbits);
    localparam int DATA_MSB = data_msb(nbits);

    state_t           state;
    logic [nbits-1:0] in_reg, out_reg;
    logic [CW-1:0]    cnt;
    logic             cs_sync, cs_rise, cs_fall, sclk_rise, sclk_fall, mosi_sync;

    spi_minion_sync_edge u_cs (.clk(clk), .reset(reset), .d(cs), .sync(cs_sync), .rise(cs_rise), .fall(cs_fall));
    spi_minion_sync_edge u_sclk (.clk(clk), .reset(reset), .d(sclk), .sync(), .rise(sclk_rise), .fall(sclk_fall));
    spi_minion_sync_edge u_mosi (.clk(clk), .reset(reset), .d(mosi), .sync(mosi_sync), .rise(), .fall());

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= WAIT_IDLE;
            in_reg           <= '0;
            out_reg          <= '0;
            cnt              <= '0;
            push_en          <= 1'b0;
            pull_en          <= 1'b0;
            frame_err        <= 1'b0;
            push_msg_val_wrt <= 1'b0;
            push_msg_val_rd  <= 1'b0;
            push_msg_data    <= '0;
        end else begin
            push_en   <= 1'b0;
            pull_en   <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                WAIT_IDLE: if (cs_sync) state <= IDLE;
                IDLE: if (cs_fall) begin
                    state   <= ACTIVE;
                    pull_en <= 1'b1;
                    cnt     <= '0;
                end
                ACTIVE: if (cs_rise) begin
                    state   <= IDLE;
                    out_reg <= '0;
                    if (cnt == CW'(nbits)) begin
                        push_en          <= 1'b1;
                        push_msg_val_wrt <= in_reg[VAL_WRT_BIT];
                        push_msg_val_rd  <= in_reg[VAL_RD_BIT];
                        push_msg_data    <= in_reg[DATA_MSB:0];
                    end else frame_err <= 1'b1;
                end else begin
                    if (sclk_rise) begin
                        in_reg <= {in_reg[nbits-2:0], mosi_sync};
                        cnt    <= (cnt == CW'(nbits + 1)) ? cnt : cnt + 1'b1;
                    end
                    if (sclk_fall) out_reg <= {out_reg[nbits-2:0], 1'b0};
                    // the adapter answers combinationally during the pull_en cycle
                    if (pull_en) out_reg <= {pull_msg_val, pull_msg_spc, pull_msg_data};
                end
                default: state <= WAIT_IDLE;
            endcase
        end
    end

    assign miso = (state == ACTIVE) & out_reg[nbits-1];
endmodule

// File: tb/tb_spi_minion_frontend.sv
// tb_spi_minion_frontend: randomized SPI master against a frame-level model with per-cycle output checks
module tb_spi_minion_frontend;
    localparam int NB = 8;

    logic          clk = 1'b0, reset = 1'b0, cs = 1'b1, sclk = 1'b0, mosi = 1'b0;
    logic          pull_msg_val = 1'b0, pull_msg_spc = 1'b0;
    logic [NB-3:0] pull_msg_data = '0;
    logic          miso, push_en, push_msg_val_wrt, push_msg_val_rd, pull_en, frame_err;
    logic [NB-3:0] push_msg_data;

    int cyc = 0, n_chk = 0, n_fail = 0;
    int n_pull = 0, n_push = 0, n_err = 0;
    int pull_cyc = -1, push_cyc = -1, err_cyc = -1, end_cyc = -1;
    logic [NB-1:0] pend = '0, fields = '0;
    logic mchk = 1'b0, mexp = 1'b0;

    spi_minion_frontend #(.nbits(NB)) dut (
        .clk(clk), .reset(reset), .cs(cs), .sclk(sclk), .mosi(mosi), .miso(miso),
        .push_en(push_en), .push_msg_val_wrt(push_msg_val_wrt), .push_msg_val_rd(push_msg_val_rd),
        .push_msg_data(push_msg_data), .pull_en(pull_en), .pull_msg_val(pull_msg_val),
        .pull_msg_spc(pull_msg_spc), .pull_msg_data(pull_msg_data), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pull_en) n_pull <= n_pull + 1;
        if (push_en) n_push <= n_push + 1;
        if (frame_err) n_err <= n_err + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Model: pulses land 3 cycles after the pad edge; miso is live only inside the frame window
    always @(negedge clk) begin
        if (cyc == push_cyc) fields = pend;
        chk("pull_en", pull_en, cyc == pull_cyc);
        chk("push_en", push_en, cyc == push_cyc);
        chk("frame_err", frame_err, cyc == err_cyc);
        chk("push_fields", {push_msg_val_wrt, push_msg_val_rd, push_msg_data}, fields);
        if (mchk) chk("miso_bit", miso, mexp);
        else if (!(cyc > pull_cyc && cyc < end_cyc)) chk("miso_idle", miso, 1'b0);
    end

    task automatic frame(input int nrise, input logic [15:0] bits, input logic [NB-1:0] resp,
                         input int rst_after, output logic [NB-1:0] got);
        logic disc;
        disc = 1'b0;
        got = '0;
        {pull_msg_val, pull_msg_spc, pull_msg_data} = resp;
        cs = 1'b0;
        pull_cyc = cyc + 3;
        end_cyc = 1 << 30;
        for (int i = 0; i < nrise; i++) begin
            if (i == rst_after) begin
                reset = 1'b0;
                disc = 1'b1;
                pull_cyc = -1;
                push_cyc = -1;
                err_cyc = -1;
                end_cyc = cyc;
                fields = '0;
                step(3);
                reset = 1'b1;
            end
            mosi = bits[nrise-1-i];
            step(4 + $urandom_range(0, 2));
            if (!disc) begin
                mchk = 1'b1;
                mexp = (i < NB) ? resp[NB-1-i] : 1'b0;
            end
            sclk = 1'b1;
            got = {got[NB-2:0], miso};
            step(1);
            mchk = 1'b0;
            step(3 + $urandom_range(0, 2));
            sclk = 1'b0;
        end
        step(4 + $urandom_range(0, 2));
        cs = 1'b1;
        if (!disc) begin
            end_cyc = cyc + 3;
            if (nrise == NB) begin
                push_cyc = cyc + 3;
                pend = bits[NB-1:0];
            end else err_cyc = cyc + 3;
        end
        step(6);
    endtask

    initial begin
        logic [NB-1:0] got;
        int p0, e0, q0, nr;
        reset = 1'b0;
        step(3);
        chk("rst_miso", miso, 0);
        chk("rst_pulses", {push_en, pull_en, frame_err}, 0);
        chk("rst_fields", {push_msg_val_wrt, push_msg_val_rd, push_msg_data}, 0);
        reset = 1'b1;
        step(6);

        q0 = n_pull; e0 = n_err;
        frame(NB, 16'h0095, 8'h00, -1, got);
        chk("wr_val_wrt", push_msg_val_wrt, 1);
        chk("wr_val_rd", push_msg_val_rd, 0);
        chk("wr_data", push_msg_data, 6'h15);
        chk("wr_pulls", n_pull - q0, 1);
        chk("wr_no_err", n_err - e0, 0);

        q0 = n_pull;
        frame(NB, 16'($urandom), 8'hEA, -1, got);
        chk("rd_miso_byte", got, 8'hEA);
        chk("rd_pulls", n_pull - q0, 1);

        p0 = n_push; e0 = n_err;
        frame(5, 16'h0013, 8'h55, -1, got);
        chk("short_err", n_err - e0, 1);
        chk("short_nopush", n_push - p0, 0);
        frame(NB, 16'h003C, 8'h81, -1, got);
        chk("after_short_data", {push_msg_val_wrt, push_msg_val_rd, push_msg_data}, 8'h3C);

        p0 = n_push; e0 = n_err;
        frame(9, 16'h01FF, 8'hC3, -1, got);
        chk("long_err", n_err - e0, 1);
        chk("long_nopush", n_push - p0, 0);

        p0 = n_push; e0 = n_err;
        frame(NB, 16'h00A5, 8'h5A, 3, got);
        chk("rst_mid_nopush", n_push - p0, 0);
        chk("rst_mid_noerr", n_err - e0, 0);
        chk("rst_mid_fields", push_msg_data, 0);
        frame(NB, 16'h007F, 8'h00, -1, got);
        chk("post_rst_data", push_msg_data, 6'h3F);
        chk("post_rst_rd", push_msg_val_rd, 1);
        chk("post_rst_wrt", push_msg_val_wrt, 0);

        p0 = n_push; e0 = n_err; q0 = n_pull;
        for (int i = 0; i < 20; i++) begin
            sclk = ~sclk;
            mosi = 1'($urandom);
            step(1 + $urandom_range(0, 5));
        end
        sclk = 1'b0;
        step(6);
        chk("idle_pulses", (n_push - p0) + (n_err - e0) + (n_pull - q0), 0);

        for (int f = 0; f < 24; f++) begin
            nr = ($urandom_range(0, 3) == 0) ? $urandom_range(3, 10) : NB;
            frame(nr, 16'($urandom), NB'($urandom), -1, got);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_minion_frontend.md
# spi_minion_frontend

SPI mode-0 minion front end that recovers frames from the raw pad signals (`cs`, `sclk`, `mosi`) in the system clock domain and drives `miso`. Each completed frame becomes a one-cycle push toward the minion adapter. Each frame start issues a one-cycle pull whose returned message is shifted out on `miso`. The block sits directly upstream of the SPI minion adapter and drives its `push_en`/`push_msg_*` and `pull_en` inputs.

## Interface
- `nbits`, 8, frame length in bits; must be ≥ 3
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-low reset
- `cs`  in  1  chip select from pad, active-low, asynchronous to `clk`
- `sclk`  in  1  SPI clock from pad, asynchronous to `clk`
- `mosi`  in  1  serial data in from pad
- `miso`  out  1  serial data out, MSB first
- `push_en`  out  1  one-cycle pulse: a complete frame is available
- `push_msg_val_wrt`  out  1  frame bit nbits-1
- `push_msg_val_rd`  out  1  frame bit nbits-2
- `push_msg_data`  out  nbits-2  frame bits nbits-3..0
- `pull_en`  out  1  one-cycle pulse at frame start
- `pull_msg_val`  in  1  pulled response is valid
- `pull_msg_spc`  in  1  downstream queue has space
- `pull_msg_data`  in  nbits-2  pulled response data
- `frame_err`  out  1  one-cycle pulse: the frame was aborted or had the wrong length

## Operation
- Synchronisation: `cs`, `sclk` and `mosi` each pass through a 2-flop synchroniser. Edge detection uses a third flop on `cs` and `sclk`.
- States:
  - WAIT_IDLE: entered on reset; held until synchronised `cs` is seen high.
  - IDLE: waiting for a frame start.
  - ACTIVE: frame in progress.
- IDLE→ACTIVE on a `cs` falling edge:
  - `pull_en`=1 for that cycle.
  - Same cycle, load the out-shift register with {`pull_msg_val`, `pull_msg_spc`, `pull_msg_data`}.
  - Clear the bit counter.
- ACTIVE, `sclk` rising edge: shift synchronised `mosi` into the in-register LSB. Bit counter increments and saturates at nbits+1.
- ACTIVE, `sclk` falling edge: out-register shifts left with zero fill.
- `miso` = out-register MSB while ACTIVE, 0 otherwise.
- ACTIVE→IDLE on a `cs` rising edge:
  - If counter == nbits: `push_en`=1 for one cycle, and the push fields present the in-register that cycle.
  - Otherwise: `frame_err`=1 for one cycle and no push.
- An `sclk` edge in the same cycle as a `cs` edge is ignored.
- `push_msg_*` hold the last completed frame between pushes. They are 0 after reset.

## Timing
- Reset values:
  - `miso`, `push_en`, `pull_en`, `frame_err`, `push_msg_*` = 0.
  - Shift registers and counter = 0.
  - State = WAIT_IDLE.
- Pad-to-edge-detect latency is 3 `clk` cycles.
- `pull_en` follows the pad `cs` falling edge by 3 cycles; `push_en` follows the pad `cs` rising edge by 3 cycles.
- `pull_msg_*` are sampled combinationally in the `pull_en` cycle; the adapter responds in that same cycle.
- Constraints on the SPI master:
  - `sclk` high and low times each ≥ 4 `clk` periods.
  - ≥ 4 `clk` periods between `cs` fall and the first `sclk` rise.
  - The first `miso` bit is valid 4 cycles after `cs` falls.
- Reset asserted mid-frame:
  - All state clears immediately; no push and no `frame_err`.
  - If `cs` is still low when reset releases, the block stays in WAIT_IDLE until `cs` goes high, so the remainder of the frame is discarded.

## Structure
- Shared package `spi_minion_pkg`:
  - Frame field positions: `VAL_WRT_BIT`=nbits-1, `VAL_RD_BIT`=nbits-2, `DATA_MSB`=nbits-3.
  - State enum {WAIT_IDLE, IDLE, ACTIVE}.
- Sub-module `spi_minion_sync_edge`:
  - 2-flop synchroniser plus edge flop.
  - Outputs: `sync`, `rise`, `fall`.
  - One instance each for `cs`, `sclk` and `mosi`; the `mosi` instance leaves `rise`/`fall` unused.

## Test plan
All scenarios use nbits=8.
- Write frame: master sends 0x95 (val_wrt=1, val_rd=0, data=0x15) → one `push_en` with `push_msg_val_wrt`=1, `push_msg_val_rd`=0, `push_msg_data`=0x15; `frame_err` stays 0.
- Read response: `pull_msg_*`={1,1,0x2A} at the `pull_en` cycle → `miso` carries 0xEA MSB first across the 8 `sclk` periods; exactly one `pull_en` per frame.
- Short frame: `cs` rises after 5 `sclk` rises → `frame_err` pulses once, no `push_en`, and the next normal frame pushes correctly.
- Long frame: 9 `sclk` rises → `frame_err` pulses, no push.
- Reset mid-frame: reset asserted after 3 bits and released with `cs` still low → no push, `pull_en` or `frame_err` until `cs` goes high; the following frame 0x7F pushes data=0x3F, val_rd=1, val_wrt=0.
- Idle lines: `sclk` toggles with `cs` high → no pulses and `miso`=0 throughout.
